// File: rtl/shared_dreg_arbiter.sv
// Round-robin owner of one shared W-bit register, loaded on behalf of N requesters.
// Latency: grant 1 cycle after the request is sampled in IDLE, write + ack 1 cycle later.
// Backpressure: a requester holds req/wdata until ack; dropping req while granted aborts the write.
module shared_dreg_arbiter #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int IW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  wdata,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    ack,
    output logic [W-1:0]    q,
    output logic [IW-1:0]   q_owner,
    output logic            busy,
    output logic [7:0]      wr_cnt
);

    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   sel_q, sel_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    ack_q, ack_d;
    logic [W-1:0]    q_q, q_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [7:0]      cnt_q, cnt_d;

    logic            found;
    logic [IW-1:0]   pick;
    logic [W-1:0]    sel_dat;
    logic            sel_req;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            v[k] = (idx == IW'(k));
        end
        return v;
    endfunction

    // First set request bit scanning upward from ptr, wrapping at N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr_q) + k) % N]) begin
                found = 1'b1;
                pick  = IW'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        sel_dat = '0;
        sel_req = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel_q == IW'(k)) begin
                sel_dat = wdata[k*W +: W];
                sel_req = req[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        q_d     = q_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    gnt_d   = onehot(pick);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (sel_req) begin
                    q_d     = sel_dat;
                    owner_d = sel_q;
                    cnt_d   = cnt_q + 8'd1;
                    ack_d   = onehot(sel_q);
                    state_d = ACK;
                end else begin
                    // Abort: pointer stays put so the aborting requester keeps its turn.
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            ACK: begin
                gnt_d   = '0;
                ack_d   = '0;
                ptr_d   = (sel_q == IW'(N-1)) ? '0 : sel_q + IW'(1);
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                ack_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign q       = q_q;
    assign q_owner = owner_q;
    assign busy    = (state_q != IDLE);
    assign wr_cnt  = cnt_q;

endmodule

// File: tb/tb_shared_dreg_arbiter.sv
// Randomized scoreboard bench for shared_dreg_arbiter against a round-robin transaction model.
module tb_shared_dreg_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*W-1:0]  wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic [W-1:0]    q;
    logic [IW-1:0]   q_owner;
    logic            busy;
    logic [7:0]      wr_cnt;

    shared_dreg_arbiter #(.N(N), .W(W), .IW(IW)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
        .gnt(gnt), .ack(ack), .q(q), .q_owner(q_owner),
        .busy(busy), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [W-1:0] dat;
        logic [7:0]  cnt;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    exp_t        sb[$];
    int          ack_cyc[$];
    int          m_ptr;
    logic [7:0]  m_cnt;
    logic [W-1:0] m_q;
    int          cnt_left[N];
    logic [W-1:0] data_arr[N][260];
    logic [N-1:0] prev_gnt, prev_ack, mon_one;
    exp_t        mon_e;

    always @(posedge clk) cyc++;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Monitor: invariants every cycle, scoreboard pop on every ack.
    always @(negedge clk) begin
        if (!rst) begin
            prev_gnt = '0;
            prev_ack = '0;
        end else begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    mon_one = '0;
                    mon_one[mon_e.idx] = 1'b1;
                    chk("ack_idx", 32'(ack), 32'(mon_one));
                    chk("ack_q", 32'(q), 32'(mon_e.dat));
                    chk("ack_owner", 32'(q_owner), 32'(mon_e.idx));
                    chk("ack_wr_cnt", 32'(wr_cnt), 32'(mon_e.cnt));
                    chk("ack_with_gnt", 32'(gnt), 32'(ack));
                    chk("gnt_before_ack", 32'(prev_gnt), 32'(ack));
                    chk("ack_one_cycle", 32'(prev_ack), 32'd0);
                end
                ack_cyc.push_back(cyc);
            end
            prev_gnt = gnt;
            prev_ack = ack;
        end
    end

    task automatic clear_counts();
        for (int i = 0; i < N; i++) cnt_left[i] = 0;
    endtask

    // Reference: each write goes to the pending requester nearest ptr in rotation order.
    task automatic run_round();
        int left[N];
        int p[N];
        int total;
        int sel;
        int budget;
        int done;
        total = 0;
        done  = 0;
        for (int i = 0; i < N; i++) begin
            left[i] = cnt_left[i];
            p[i]    = 0;
            total  += left[i];
        end
        for (int w = 0; w < total; w++) begin
            sel = -1;
            for (int k = 0; k < N; k++)
                if (sel < 0 && left[(m_ptr + k) % N] > 0) sel = (m_ptr + k) % N;
            m_cnt = m_cnt + 8'd1;
            m_q   = data_arr[sel][p[sel]];
            sb.push_back('{sel, m_q, m_cnt});
            p[sel]++;
            left[sel]--;
            m_ptr = (sel + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            left[i] = cnt_left[i];
            p[i]    = 0;
            req[i]  = (left[i] > 0);
            wdata[i*W +: W] = data_arr[i][0];
        end
        ack_cyc.delete();
        budget = total * 3 + 20;
        while (done < total && budget > 0) begin
            @(negedge clk);
            budget--;
            for (int i = 0; i < N; i++) begin
                if (ack[i] && left[i] > 0) begin
                    done++;
                    p[i]++;
                    left[i]--;
                    if (left[i] == 0) req[i] = 1'b0;
                    else wdata[i*W +: W] = data_arr[i][p[i]];
                end
            end
        end
        if (done < total) chk("round_timeout", 32'(done), 32'(total));
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        rst   = 1'b1;
        m_ptr = 0;
        m_cnt = '0;
        m_q   = '0;
        sb.delete();
    endtask

    initial begin
        int bud;
        rst   = 1'b0;
        req   = '1;
        wdata = '0;
        m_ptr = 0;
        m_cnt = '0;
        m_q   = '0;

        // Reset held with all requesting
        #50;
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_owner", 32'(q_owner), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        #50;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            cnt_left[i] = 1;
            data_arr[i][0] = W'($urandom);
        end
        run_round();

        // Single request timing from IDLE
        @(negedge clk);
        wdata[2*W +: W] = 8'hA5;
        req = 4'b0100;
        m_cnt = m_cnt + 8'd1;
        m_q   = 8'hA5;
        sb.push_back('{2, 8'hA5, m_cnt});
        m_ptr = 3;
        @(negedge clk);
        chk("t2_gnt", 32'(gnt), 32'h4);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_no_ack_yet", 32'(ack), 32'd0);
        @(negedge clk);
        chk("t2_ack", 32'(ack), 32'h4);
        req = '0;
        @(negedge clk);
        chk("t2_gnt_clear", 32'(gnt), 32'd0);
        chk("t2_idle", 32'(busy), 32'd0);
        chk("t2_q_hold", 32'(q), 32'hA5);

        // All four continuously, five writes
        do_reset();
        clear_counts();
        cnt_left[0] = 2; data_arr[0][0] = 8'h10; data_arr[0][1] = 8'h10;
        cnt_left[1] = 1; data_arr[1][0] = 8'h21;
        cnt_left[2] = 1; data_arr[2][0] = 8'h32;
        cnt_left[3] = 1; data_arr[3][0] = 8'h43;
        run_round();
        chk("t3_ack_count", 32'(ack_cyc.size()), 32'd5);
        if (ack_cyc.size() == 5)
            for (int k = 1; k < 5; k++)
                chk("t3_ack_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd3);
        chk("t3_wr_cnt", 32'(wr_cnt), 32'd5);
        chk("t3_q_last", 32'(q), 32'h10);

        // Abort: grant to 1 withdrawn during GRANT
        clear_counts();
        cnt_left[3] = 1; data_arr[3][0] = 8'h77;
        run_round();
        @(negedge clk);
        req = 4'b0010;
        wdata[1*W +: W] = 8'hEE;
        @(negedge clk);
        chk("t4_gnt", 32'(gnt), 32'h2);
        req = '0;
        @(negedge clk);
        chk("t4_gnt_drop", 32'(gnt), 32'd0);
        chk("t4_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t4_no_ack", 32'(ack), 32'd0);
        chk("t4_q_unchanged", 32'(q), 32'(m_q));
        chk("t4_cnt_unchanged", 32'(wr_cnt), 32'(m_cnt));
        clear_counts();
        cnt_left[0] = 1; data_arr[0][0] = 8'h01;
        cnt_left[1] = 1; data_arr[1][0] = 8'h02;
        run_round();

        // Reset during ACK of requester 3
        @(negedge clk);
        req = 4'b1000;
        wdata[3*W +: W] = 8'h5C;
        sb.push_back('{3, 8'h5C, m_cnt + 8'd1});
        bud = 10;
        while (!ack[3] && bud > 0) begin
            @(negedge clk);
            bud--;
        end
        chk("t5_reached_ack", 32'(ack[3]), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("t5_gnt", 32'(gnt), 32'd0);
        chk("t5_ack", 32'(ack), 32'd0);
        chk("t5_q", 32'(q), 32'd0);
        chk("t5_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
        req = '0;
        m_ptr = 0;
        m_cnt = '0;
        m_q   = '0;
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        clear_counts();
        cnt_left[3] = 1; data_arr[3][0] = 8'hC3;
        run_round();

        // Randomized rounds
        for (int r = 0; r < 25; r++) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                cnt_left[i] = mask[i] ? int'($urandom_range(1, 3)) : 0;
                for (int j = 0; j < 3; j++) data_arr[i][j] = W'($urandom);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_round();
        end

        // Counter wrap: 256 writes from requester 1
        do_reset();
        clear_counts();
        cnt_left[1] = 256;
        for (int j = 0; j < 256; j++) data_arr[1][j] = W'($urandom);
        run_round();
        chk("t6_wr_cnt_wrap", 32'(wr_cnt), 32'd0);
        chk("t6_q_last", 32'(q), 32'(data_arr[1][255]));
        chk("t6_owner", 32'(q_owner), 32'd1);

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/shared_dreg_arbiter.md
Name: shared_dreg_arbiter

Overview:
Round-robin arbiter and sequencer that shares one W-bit D-type storage register between N requesters. Each requester raises a request with write data. The block grants one requester at a time, loads that requester's data into the shared register, and returns a one-cycle acknowledge. It sits between requester logic and the shared register, which it owns internally. It also exposes the stored value, the current owner and a write counter.

Parameters:
N, 4, number of requesters (2..8)
W, 8, width of the shared register and of each requester's data
IW, 2, owner index width, equal to clog2(N)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  N  per-requester request; bit i belongs to requester i
wdata  input  N*W  packed write data; requester i owns bits [i*W +: W]
gnt  output  N  one-hot grant, registered
ack  output  N  one-hot write acknowledge, one cycle, registered
q  output  W  shared register contents
q_owner  output  IW  index of the requester that last wrote q
busy  output  1  high whenever the FSM is not IDLE
wr_cnt  output  8  count of completed writes, wraps 255 -> 0

Behaviour:
- Reset (rst = 0, asynchronous), all values immediate:
  - q = 0, q_owner = 0, gnt = 0, ack = 0, busy = 0, wr_cnt = 0.
  - Priority pointer ptr = 0; state = IDLE.
- Reset asserted mid-transaction aborts it with no write and no ack. Release is sampled at the next rising edge.
- State IDLE:
  - If req is nonzero, select the first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N).
  - Register gnt = onehot(sel) and sel_idx = sel; go to GRANT.
  - If req = 0, stay in IDLE.
- State GRANT (gnt[sel] high, busy high):
  - If req[sel] is still high: q <= wdata[sel*W +: W], q_owner <= sel, wr_cnt <= wr_cnt + 1, ack[sel] <= 1; go to ACK.
  - If req[sel] has dropped (abort): gnt <= 0, q unchanged, no ack, ptr unchanged; go to IDLE.
- State ACK (ack[sel] and gnt[sel] high for exactly one cycle):
  - The new q is visible this cycle.
  - On the edge: gnt <= 0, ack <= 0, ptr <= (sel + 1) mod N; go to IDLE.
- Timing:
  - Request sampled in IDLE at edge k gives gnt at k+1, q update plus ack at k+2, and return to IDLE at k+3.
  - Minimum 3 cycles per write; a new grant appears no earlier than edge k+4.
- Handshake rules:
  - A requester holds req and wdata stable until it sees ack.
  - It drops req in the ack cycle if it has no further write.
  - A req still high in IDLE is treated as a new request.
- Fairness: with all N requesting continuously, grants rotate 0, 1, ..., N-1, 0. No requester waits more than N-1 other writes.
- Simultaneous events:
  - Changes on non-selected req bits during GRANT or ACK are ignored.
  - wdata of the selected requester is sampled only on the GRANT -> ACK edge.
- Invariants:
  - gnt and ack are always zero or one-hot.
  - ack is never high without the matching gnt.
- wr_cnt wraps modulo 256 and does not count aborts.

Test Plan:
1. Hold rst = 0 for 100 ns with req = 4'b1111 -> q = 0, gnt = 0, ack = 0, busy = 0, wr_cnt = 0. After release, the first grant goes to requester 0.
2. From IDLE, single req[2] = 1 with wdata[2] = 8'hA5 -> gnt = 4'b0100 one edge later. Next edge: q = 8'hA5, q_owner = 2, ack = 4'b0100, wr_cnt = 1. Then gnt = 0, busy = 0.
3. All four requesting continuously with data 8'h10, 8'h21, 8'h32, 8'h43 -> ack order 0, 1, 2, 3, 0 every 3 cycles, q following the same sequence, wr_cnt = 5 after 5 writes.
4. Abort: req[1] raised, then dropped in the GRANT cycle -> no ack, q unchanged, wr_cnt unchanged. Next grant with req = 4'b0011 goes to 0 (ptr unchanged).
5. Reset mid-op: rst driven to 0 during ACK of requester 3 -> gnt, ack, q, wr_cnt immediately 0, without waiting for a clock edge. After release, req[3] alone produces a fresh grant.
6. Wrap: 256 single writes from requester 1 -> wr_cnt returns to 0, and the last q equals the last wdata.
